// File: rtl/cordic_pkg.sv
// Shared constants for the multimode CORDIC engine: arctangent table, mode
// encodings and the CORDIC gain.
package cordic_pkg;

    localparam logic MODE_VECT = 1'b0;
    localparam logic MODE_ROT  = 1'b1;

    // K ~= 1.64676 in Q16
    localparam int CORDIC_GAIN_Q16 = 107922;

    // round(atan(2^-i) / (2*pi) * 2^32): binary angle where 2^32 is a full turn
    localparam logic [31:0] ATAN_TAB [32] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
    };

    // Table entry reduced to angle_w bits with round-half-up.
    function automatic logic [31:0] atan_entry(input int shift, input int angle_w);
        logic [32:0] sum;
        logic [4:0]  idx;
        idx = shift[4:0];
        if (angle_w >= 32) begin
            return ATAN_TAB[idx];
        end
        sum = {1'b0, ATAN_TAB[idx]} + (33'd1 << (31 - angle_w));
        sum = sum >> (32 - angle_w);
        return sum[31:0];
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation; valid and mode ride along with the data.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int SHIFT   = 0,
    parameter int DATA_W  = 16,
    parameter int ANGLE_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      in_valid,
    input  logic                      in_mode,
    input  logic signed [DATA_W+1:0]  x_in,
    input  logic signed [DATA_W+1:0]  y_in,
    input  logic        [ANGLE_W-1:0] z_in,
    output logic                      out_valid,
    output logic                      out_mode,
    output logic signed [DATA_W+1:0]  x_out,
    output logic signed [DATA_W+1:0]  y_out,
    output logic        [ANGLE_W-1:0] z_out
);

    localparam int XW = DATA_W + 2;
    localparam logic [31:0]        ATAN_FULL = atan_entry(SHIFT, ANGLE_W);
    localparam logic [ANGLE_W-1:0] ATAN      = ATAN_FULL[ANGLE_W-1:0];

    logic signed [XW-1:0]  x_sh;
    logic signed [XW-1:0]  y_sh;
    logic                  d_pos;
    logic signed [XW-1:0]  x_next;
    logic signed [XW-1:0]  y_next;
    logic [ANGLE_W-1:0]    z_next;

    always_comb begin
        x_sh   = x_in >>> SHIFT;
        y_sh   = y_in >>> SHIFT;
        // Vectoring drives y toward zero, rotation drives z toward zero.
        d_pos  = (in_mode == MODE_VECT) ? y_in[XW-1] : ~z_in[ANGLE_W-1];
        x_next = d_pos ? (x_in - y_sh) : (x_in + y_sh);
        y_next = d_pos ? (y_in + x_sh) : (y_in - x_sh);
        z_next = d_pos ? (z_in - ATAN) : (z_in + ATAN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
        end else if (ena) begin
            out_valid <= in_valid;
            out_mode  <= in_mode;
            x_out     <= x_next;
            y_out     <= y_next;
            z_out     <= z_next;
        end
    end

endmodule

// File: rtl/cordic_multimode_proc.sv
// Pipelined CORDIC with per-sample vectoring/rotation mode: quadrant-folding
// pre-stage, STAGES micro-rotations, output register.
module cordic_multimode_proc
    import cordic_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ANGLE_W = 16,
    parameter int STAGES  = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      in_valid,
    input  logic                      in_mode,
    input  logic signed [DATA_W-1:0]  x_in,
    input  logic signed [DATA_W-1:0]  y_in,
    input  logic        [ANGLE_W-1:0] z_in,
    output logic                      out_valid,
    output logic                      out_mode,
    output logic signed [DATA_W+1:0]  x_out,
    output logic signed [DATA_W+1:0]  y_out,
    output logic        [ANGLE_W-1:0] z_out
);

    localparam int XW = DATA_W + 2;
    localparam logic [ANGLE_W-1:0] HALF_TURN = {1'b1, {(ANGLE_W-1){1'b0}}};

    logic signed [XW-1:0]  x_ext;
    logic signed [XW-1:0]  y_ext;
    logic                  flip;
    logic signed [XW-1:0]  x_pre_next;
    logic signed [XW-1:0]  y_pre_next;
    logic [ANGLE_W-1:0]    z_pre_next;

    logic                  valid_chain [STAGES+1];
    logic                  mode_chain  [STAGES+1];
    logic signed [XW-1:0]  x_chain     [STAGES+1];
    logic signed [XW-1:0]  y_chain     [STAGES+1];
    logic [ANGLE_W-1:0]    z_chain     [STAGES+1];

    // Fold the input into the +-90 degree convergence range; the folded-out
    // half turn is preloaded into z so no separate quadrant tag is needed.
    always_comb begin
        x_ext = {{2{x_in[DATA_W-1]}}, x_in};
        y_ext = {{2{y_in[DATA_W-1]}}, y_in};
        if (in_mode == MODE_VECT) begin
            flip       = x_in[DATA_W-1];
            z_pre_next = flip ? HALF_TURN : '0;
        end else begin
            flip       = z_in[ANGLE_W-1] ^ z_in[ANGLE_W-2];
            z_pre_next = flip ? (z_in + HALF_TURN) : z_in;
        end
        x_pre_next = flip ? -x_ext : x_ext;
        y_pre_next = flip ? -y_ext : y_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_chain[0] <= 1'b0;
            mode_chain[0]  <= 1'b0;
            x_chain[0]     <= '0;
            y_chain[0]     <= '0;
            z_chain[0]     <= '0;
        end else if (ena) begin
            valid_chain[0] <= in_valid;
            mode_chain[0]  <= in_mode;
            x_chain[0]     <= x_pre_next;
            y_chain[0]     <= y_pre_next;
            z_chain[0]     <= z_pre_next;
        end
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            cordic_stage #(
                .SHIFT   (gi),
                .DATA_W  (DATA_W),
                .ANGLE_W (ANGLE_W)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .ena       (ena),
                .in_valid  (valid_chain[gi]),
                .in_mode   (mode_chain[gi]),
                .x_in      (x_chain[gi]),
                .y_in      (y_chain[gi]),
                .z_in      (z_chain[gi]),
                .out_valid (valid_chain[gi+1]),
                .out_mode  (mode_chain[gi+1]),
                .x_out     (x_chain[gi+1]),
                .y_out     (y_chain[gi+1]),
                .z_out     (z_chain[gi+1])
            );
        end
    endgenerate

    // A zero vector never moves, so its z would sum every table entry;
    // report angle 0 instead.
    logic zero_vec;
    assign zero_vec = (mode_chain[STAGES] == MODE_VECT)
                    && (x_chain[STAGES] == '0) && (y_chain[STAGES] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
        end else if (ena) begin
            out_valid <= valid_chain[STAGES];
            out_mode  <= mode_chain[STAGES];
            x_out     <= x_chain[STAGES];
            y_out     <= y_chain[STAGES];
            z_out     <= zero_vec ? '0 : z_chain[STAGES];
        end
    end

endmodule
